oldland_memory: RTL and testbench
=================================

Name: oldland_memory

Overview:
- Memory-access stage of the Oldland pipeline, directly downstream of the execute stage.
- Consumes execute's registered outputs: ALU result / effective address, load/store strobes, access width, write value, destination register and write-enable.
- Performs data-bus transactions with a request/acknowledge handshake, stalling the pipeline while a transaction is outstanding.
- Aligns and zero-extends load data, and presents the result to writeback one cycle later.

Parameters:
- TIMEOUT, 16: cycles in BUSY without d_ack before the access is aborted with bus_error (range 2..255).

Ports:
- clk  in  1  pipeline clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- alu_out  in  32  effective address for loads/stores; result otherwise.
- mem_load  in  1  instruction is a load.
- mem_store  in  1  instruction is a store.
- mem_width  in  2  access width: 2'b00 byte, 2'b01 half, 2'b10 word; 2'b11 is treated as misaligned.
- wr_val  in  32  store data for stores; register result otherwise.
- wr_result  in  1  instruction writes rd.
- rd_sel  in  3  destination register.
- d_addr  out  32  word-aligned bus address ({alu_out[31:2],2'b00}).
- d_bytesel  out  4  byte-lane enables.
- d_wr_en  out  1  bus write (1) / read (0).
- d_access  out  1  bus request; held until d_ack or timeout.
- d_wr_val  out  32  lane-replicated store data.
- d_data  in  32  read data, valid when d_ack=1.
- d_ack  in  1  transaction complete.
- mem_stall  out  1  upstream must hold its outputs stable.
- wb_en  out  1  writeback enable.
- wb_sel  out  3  writeback register.
- wb_data  out  32  writeback value.
- bus_error  out  1  one-cycle pulse: misaligned access or timeout.

Behaviour:
- Reset: state IDLE; d_access, d_wr_en, d_bytesel, d_addr, d_wr_val, wb_en, wb_sel, wb_data, bus_error and the timeout counter all 0. Reset during BUSY drops d_access on the next edge, with no writeback and no bus_error.
- States: IDLE, BUSY.
- IDLE, no memory operation (mem_load=mem_store=0):
  - Next edge: wb_en<=wr_result, wb_sel<=rd_sel, wb_data<=wr_val. Latency is 1 cycle.
  - mem_stall=0.
- IDLE, aligned load or store:
  - mem_stall=1 combinationally in that cycle.
  - Next edge: register d_addr, d_bytesel, d_wr_en=mem_store and d_wr_val; set d_access=1, counter=0, go BUSY; wb_en<=0.
- Alignment rules:
  - A half access with alu_out[0]=1, a word access with alu_out[1:0]!=0, or width 2'b11 is misaligned.
  - Misaligned in IDLE: no bus access, mem_stall=0; next edge bus_error=1 for one cycle and wb_en=0.
- Byte lanes (little-endian):
  - Byte: d_bytesel = 4'b0001 << alu_out[1:0]; d_wr_val = {4{wr_val[7:0]}}.
  - Half: d_bytesel = alu_out[1] ? 4'b1100 : 4'b0011; d_wr_val = {2{wr_val[15:0]}}.
  - Word: d_bytesel = 4'b1111; d_wr_val = wr_val.
- BUSY, handling of upstream: inputs are ignored and upstream holds them; mem_stall = !d_ack.
- BUSY, d_ack=1:
  - Next edge: d_access<=0, d_wr_en<=0, d_bytesel<=0, go IDLE.
  - For a load: wb_en<=1, wb_sel<=latched rd, wb_data<=selected lane zero-extended to 32 bits (byte from d_data[8*a+7:8*a]; half from d_data[31:16] or d_data[15:0]).
  - For a store: wb_en<=0.
  - mem_stall=0 in the ack cycle, so upstream advances on the same edge.
- BUSY, no ack: counter increments each cycle. When counter reaches TIMEOUT-1 without ack:
  - mem_stall=0 in that cycle.
  - Next edge: d_access<=0, bus_error<=1 for one cycle, wb_en<=0, go IDLE.
  - An ack arriving in that same cycle wins: normal completion, no error.
- Other rules:
  - d_ack in IDLE is ignored.
  - mem_load and mem_store both set: treated as a store.
  - bus_error is 0 in every cycle not specified above.

Test Plan:
- Word load at 0x0000_1004, rd=3, d_ack 2 cycles after d_access, d_data=0xDEADBEEF: d_addr=0x1004, d_bytesel=1111, d_wr_en=0; mem_stall high for 3 cycles; then wb_en=1, wb_sel=3, wb_data=0xDEADBEEF.
- Byte store of 0x000000A5 to 0x2003: d_bytesel=1000, d_wr_val=0xA5A5A5A5, d_wr_en=1; one-cycle ack; wb_en stays 0.
- Half load from 0x3002 with d_data=0x8001_1234: d_bytesel=1100, wb_data=0x0000_8001 (zero-extended).
- Back-to-back: ALU op (wr_val=7, rd=1) followed by word load with immediate ack: wb of 7 to r1, then load result 1 cycle after ack, with no lost or duplicated writeback.
- Misaligned word load at 0x4001: d_access stays 0, bus_error pulses 1 cycle, wb_en=0. Separately, no d_ack with TIMEOUT=16: d_access deasserts after 16 BUSY cycles and bus_error pulses.
- rst asserted on the 2nd BUSY cycle: next cycle d_access=0, wb_en=0, bus_error=0, state IDLE; a later d_ack is ignored.

Source files
------------

// File: rtl/oldland_memory_if.sv
// rtl/oldland_memory_if.sv - data-bus interface between the Oldland memory stage and memory
//
// Ports (master = memory stage, slave = memory):
//   d_addr     word-aligned bus address
//   d_bytesel  byte-lane enables
//   d_wr_en    1 = write, 0 = read
//   d_access   bus request, held until d_ack or timeout
//   d_wr_val   lane-replicated store data
//   d_data     read data, valid with d_ack
//   d_ack      transaction complete
interface oldland_memory_if;
  logic [31:0] d_addr;
  logic [3:0]  d_bytesel;
  logic        d_wr_en;
  logic        d_access;
  logic [31:0] d_wr_val;
  logic [31:0] d_data;
  logic        d_ack;

  modport master (
    output d_addr, d_bytesel, d_wr_en, d_access, d_wr_val,
    input  d_data, d_ack
  );

  modport slave (
    input  d_addr, d_bytesel, d_wr_en, d_access, d_wr_val,
    output d_data, d_ack
  );
endinterface

// File: rtl/oldland_memory.sv
// rtl/oldland_memory.sv - Oldland pipeline memory-access stage
//
// Ports:
//   clk, rst    pipeline clock, synchronous active-high reset
//   alu_out     effective address (loads/stores) or ALU result
//   mem_load    instruction is a load
//   mem_store   instruction is a store (wins if both are set)
//   mem_width   00 byte, 01 half, 10 word, 11 misaligned
//   wr_val      store data or register result
//   wr_result   instruction writes rd
//   rd_sel      destination register
//   bus         data-bus master (oldland_memory_if.master)
//   mem_stall   upstream must hold its outputs
//   wb_en, wb_sel, wb_data   registered writeback to the next stage
//   bus_error   one-cycle pulse on misaligned access or bus timeout
module oldland_memory #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             alu_out,
  input  logic                    mem_load,
  input  logic                    mem_store,
  input  logic [1:0]              mem_width,
  input  logic [31:0]             wr_val,
  input  logic                    wr_result,
  input  logic [2:0]              rd_sel,
  oldland_memory_if.master        bus,
  output logic                    mem_stall,
  output logic                    wb_en,
  output logic [2:0]              wb_sel,
  output logic [31:0]             wb_data,
  output logic                    bus_error
);

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_t;

  state_t      r_state;
  logic [7:0]  r_count;
  logic        r_load;
  logic [2:0]  r_rd;
  logic [1:0]  r_lane;
  logic [1:0]  r_width;

  logic        w_mem_op;
  logic        w_misaligned;
  logic        w_timeout;
  logic [3:0]  w_bytesel;
  logic [31:0] w_wr_val;
  logic [7:0]  w_byte;
  logic [31:0] w_load_data;

  assign w_mem_op = mem_load | mem_store;

  assign w_misaligned = (mem_width == 2'b11) ||
                        (mem_width == 2'b01 && alu_out[0]) ||
                        (mem_width == 2'b10 && alu_out[1:0] != 2'b00);

  // Last BUSY cycle before the access is abandoned.
  assign w_timeout = (r_count == 8'(TIMEOUT - 1));

  // An ack in the timeout cycle still completes normally, so stall drops in
  // both cases and upstream advances on the same edge.
  assign mem_stall = (r_state == S_IDLE) ? (w_mem_op && !w_misaligned)
                                         : (!bus.d_ack && !w_timeout);

  // Little-endian lane enables and store-data replication.
  always_comb begin
    w_bytesel = 4'b1111;
    w_wr_val  = wr_val;
    case (mem_width)
      2'b00: begin
        w_bytesel = 4'b0001 << alu_out[1:0];
        w_wr_val  = {4{wr_val[7:0]}};
      end
      2'b01: begin
        w_bytesel = alu_out[1] ? 4'b1100 : 4'b0011;
        w_wr_val  = {2{wr_val[15:0]}};
      end
      default: ;
    endcase
  end

  // Lane selection of returned data, zero-extended.
  always_comb begin
    case (r_lane)
      2'd0:    w_byte = bus.d_data[7:0];
      2'd1:    w_byte = bus.d_data[15:8];
      2'd2:    w_byte = bus.d_data[23:16];
      default: w_byte = bus.d_data[31:24];
    endcase
    w_load_data = bus.d_data;
    case (r_width)
      2'b00:   w_load_data = {24'd0, w_byte};
      2'b01:   w_load_data = {16'd0, r_lane[1] ? bus.d_data[31:16] : bus.d_data[15:0]};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_count       <= 8'd0;
      r_load        <= 1'b0;
      r_rd          <= 3'd0;
      r_lane        <= 2'd0;
      r_width       <= 2'd0;
      bus.d_addr    <= 32'd0;
      bus.d_bytesel <= 4'd0;
      bus.d_wr_en   <= 1'b0;
      bus.d_access  <= 1'b0;
      bus.d_wr_val  <= 32'd0;
      wb_en         <= 1'b0;
      wb_sel        <= 3'd0;
      wb_data       <= 32'd0;
      bus_error     <= 1'b0;
    end else begin
      bus_error <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_mem_op) begin
            wb_en <= 1'b0;
            if (w_misaligned) begin
              bus_error <= 1'b1;
            end else begin
              bus.d_addr    <= {alu_out[31:2], 2'b00};
              bus.d_bytesel <= w_bytesel;
              bus.d_wr_en   <= mem_store;
              bus.d_wr_val  <= w_wr_val;
              bus.d_access  <= 1'b1;
              r_count       <= 8'd0;
              // A load+store combination is a store: no writeback.
              r_load        <= mem_load & ~mem_store;
              r_rd          <= rd_sel;
              r_lane        <= alu_out[1:0];
              r_width       <= mem_width;
              r_state       <= S_BUSY;
            end
          end else begin
            wb_en   <= wr_result;
            wb_sel  <= rd_sel;
            wb_data <= wr_val;
          end
        end

        S_BUSY: begin
          if (bus.d_ack) begin
            bus.d_access  <= 1'b0;
            bus.d_wr_en   <= 1'b0;
            bus.d_bytesel <= 4'd0;
            wb_en         <= r_load;
            if (r_load) begin
              wb_sel  <= r_rd;
              wb_data <= w_load_data;
            end
            r_state <= S_IDLE;
          end else if (w_timeout) begin
            bus.d_access  <= 1'b0;
            bus.d_wr_en   <= 1'b0;
            bus.d_bytesel <= 4'd0;
            bus_error     <= 1'b1;
            wb_en         <= 1'b0;
            r_state       <= S_IDLE;
          end else begin
            r_count <= r_count + 8'd1;
            wb_en   <= 1'b0;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_oldland_memory.sv
// tb/tb_oldland_memory.sv - scoreboard testbench for oldland_memory
//
// Stimulus issues directed vectors and pushes hand-computed expected bus
// requests, writebacks and bus errors into queues; a negedge monitor pops
// and compares whenever the DUT presents one of those events.
module tb_oldland_memory;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] alu_out = '0;
  logic        mem_load = 1'b0;
  logic        mem_store = 1'b0;
  logic [1:0]  mem_width = '0;
  logic [31:0] wr_val = '0;
  logic        wr_result = 1'b0;
  logic [2:0]  rd_sel = '0;
  logic        mem_stall;
  logic        wb_en;
  logic [2:0]  wb_sel;
  logic [31:0] wb_data;
  logic        bus_error;

  oldland_memory_if bus ();

  oldland_memory #(.TIMEOUT(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .alu_out   (alu_out),
    .mem_load  (mem_load),
    .mem_store (mem_store),
    .mem_width (mem_width),
    .wr_val    (wr_val),
    .wr_result (wr_result),
    .rd_sel    (rd_sel),
    .bus       (bus.master),
    .mem_stall (mem_stall),
    .wb_en     (wb_en),
    .wb_sel    (wb_sel),
    .wb_data   (wb_data),
    .bus_error (bus_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  bsel;
    logic        wr;
    logic [31:0] wv;
  } req_t;

  typedef struct packed {
    logic [2:0]  sel;
    logic [31:0] data;
  } wb_t;

  req_t req_q[$];
  wb_t  wb_q[$];
  int   err_q[$];

  int n_total = 0;
  int n_pass  = 0;
  logic prev_access = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: compares every DUT-presented event against the scoreboard.
  always @(negedge clk) begin
    if (bus.d_access && !prev_access) begin
      if (req_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_req: addr=%0h bsel=%0h", bus.d_addr, bus.d_bytesel);
      end else begin
        req_t e;
        e = req_q.pop_front();
        check("bus_req", {bus.d_addr, bus.d_bytesel, bus.d_wr_en, bus.d_wr_val}, e);
      end
    end
    prev_access = bus.d_access;

    if (wb_en) begin
      if (wb_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_wb: sel=%0d data=%0h", wb_sel, wb_data);
      end else begin
        wb_t e;
        e = wb_q.pop_front();
        check("writeback", {wb_sel, wb_data}, e);
      end
    end

    if (bus_error) begin
      if (err_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_bus_error: bus_error=%0b", bus_error);
      end else begin
        void'(err_q.pop_front());
        check("bus_error", bus_error, 1'b1);
      end
    end
  end

  task automatic idle_inputs();
    mem_load  = 1'b0;
    mem_store = 1'b0;
    mem_width = 2'b00;
    wr_result = 1'b0;
    alu_out   = '0;
    wr_val    = '0;
    rd_sel    = '0;
  endtask

  // Non-memory instruction; one cycle in the stage.
  task automatic alu_op(input logic [31:0] v, input logic [2:0] rd, input logic wr);
    idle_inputs();
    wr_val    = v;
    rd_sel    = rd;
    wr_result = wr;
    if (wr) wb_q.push_back('{sel: rd, data: v});
    @(negedge clk);
    check("alu_no_stall", mem_stall, 1'b0);
    @(posedge clk); #1;
  endtask

  // Aligned memory access; ack arrives after dly BUSY cycles without ack.
  task automatic mem_op(input logic ld, input logic st, input logic [1:0] w,
                        input logic [31:0] a, input logic [31:0] v, input logic [2:0] rd,
                        input int dly, input logic [31:0] rdata,
                        input logic [3:0] exp_bsel, input logic [31:0] exp_wv,
                        input logic [31:0] exp_wb);
    int stalls = 0;
    mem_load  = ld;
    mem_store = st;
    mem_width = w;
    alu_out   = a;
    wr_val    = v;
    rd_sel    = rd;
    wr_result = ld;
    req_q.push_back('{addr: {a[31:2], 2'b00}, bsel: exp_bsel, wr: st, wv: exp_wv});
    if (ld && !st) wb_q.push_back('{sel: rd, data: exp_wb});
    @(negedge clk);
    if (mem_stall) stalls++;
    @(posedge clk); #1;
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      if (mem_stall) stalls++;
      @(posedge clk); #1;
    end
    bus.d_ack  = 1'b1;
    bus.d_data = rdata;
    @(negedge clk);
    if (mem_stall) stalls++;
    @(posedge clk); #1;
    bus.d_ack  = 1'b0;
    bus.d_data = '0;
    idle_inputs();
    check("stall_cycles", stalls, dly + 1);
  endtask

  task automatic misaligned(input logic [1:0] w, input logic [31:0] a);
    idle_inputs();
    mem_load  = 1'b1;
    mem_width = w;
    alu_out   = a;
    wr_result = 1'b1;
    rd_sel    = 3'd7;
    err_q.push_back(1);
    @(negedge clk);
    check("misaligned_no_stall", mem_stall, 1'b0);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check("misaligned_no_access", bus.d_access, 1'b0);
    check("misaligned_no_wb", wb_en, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int cnt;
    bus.d_ack  = 1'b0;
    bus.d_data = '0;
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_outputs",
          {bus.d_access, bus.d_wr_en, bus.d_bytesel, bus.d_addr, bus.d_wr_val,
           wb_en, wb_sel, wb_data, bus_error, mem_stall}, '0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Word load, ack two cycles after d_access.
    mem_op(1, 0, 2'b10, 32'h0000_1004, 32'h0, 3'd3, 2, 32'hDEAD_BEEF,
           4'b1111, 32'h0, 32'hDEAD_BEEF);
    // Byte store to lane 3, single-cycle ack.
    mem_op(0, 1, 2'b00, 32'h0000_2003, 32'h0000_00A5, 3'd0, 0, 32'h0,
           4'b1000, 32'hA5A5_A5A5, 32'h0);
    // Half load from upper half, zero-extended.
    mem_op(1, 0, 2'b01, 32'h0000_3002, 32'h0, 3'd5, 1, 32'h8001_1234,
           4'b1100, 32'h0, 32'h0000_8001);
    // Back-to-back: ALU writeback then load with immediate ack.
    alu_op(32'd7, 3'd1, 1'b1);
    mem_op(1, 0, 2'b10, 32'h0000_0100, 32'h0, 3'd2, 0, 32'h1234_5678,
           4'b1111, 32'h0, 32'h1234_5678);
    alu_op(32'h55, 3'd4, 1'b0);
    // Byte load from lane 1; store data is still lane-replicated.
    mem_op(1, 0, 2'b00, 32'h0000_1001, 32'h1234_5678, 3'd4, 1, 32'h1122_3344,
           4'b0010, 32'h7878_7878, 32'h0000_0033);
    // Half store to lower half.
    mem_op(0, 1, 2'b01, 32'h0000_7000, 32'h0000_1236, 3'd0, 0, 32'h0,
           4'b0011, 32'h1236_1236, 32'h0);
    // Load and store both set: behaves as a store.
    mem_op(1, 1, 2'b10, 32'h0000_8000, 32'hCAFE_F00D, 3'd6, 0, 32'hFFFF_FFFF,
           4'b1111, 32'hCAFE_F00D, 32'h0);
    // Ack in the timeout cycle wins: normal completion, no error.
    mem_op(1, 0, 2'b10, 32'h0000_9000, 32'h0, 3'd6, 15, 32'h0BAD_CAFE,
           4'b1111, 32'h0, 32'h0BAD_CAFE);
    alu_op(32'hABCD_0001, 3'd2, 1'b1);

    misaligned(2'b10, 32'h0000_4001);
    misaligned(2'b01, 32'h0000_4003);
    misaligned(2'b11, 32'h0000_4000);

    // Timeout: no ack ever.
    idle_inputs();
    mem_load  = 1'b1;
    mem_width = 2'b10;
    alu_out   = 32'h0000_5000;
    wr_result = 1'b1;
    rd_sel    = 3'd3;
    req_q.push_back('{addr: 32'h0000_5000, bsel: 4'b1111, wr: 1'b0, wv: 32'h0});
    err_q.push_back(1);
    @(posedge clk); #1;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.d_access) cnt++;
      if (!mem_stall) idle_inputs();
      if (!bus.d_access) break;
    end
    check("timeout_busy_cycles", cnt, 16);
    @(posedge clk); #1;

    // Reset during the second BUSY cycle; a later ack is ignored.
    mem_load  = 1'b1;
    mem_width = 2'b10;
    alu_out   = 32'h0000_6000;
    wr_result = 1'b1;
    rd_sel    = 3'd5;
    req_q.push_back('{addr: 32'h0000_6000, bsel: 4'b1111, wr: 1'b0, wv: 32'h0});
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    idle_inputs();
    @(posedge clk); #1;
    rst = 1'b0;
    bus.d_ack  = 1'b1;
    bus.d_data = 32'h5555_5555;
    @(negedge clk);
    check("rst_busy_access", bus.d_access, 1'b0);
    check("rst_busy_wb", wb_en, 1'b0);
    check("rst_busy_err", bus_error, 1'b0);
    check("rst_busy_idle_stall", mem_stall, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check("ack_in_idle_access", bus.d_access, 1'b0);
    check("ack_in_idle_wb", wb_en, 1'b0);
    bus.d_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("req_q_drained", req_q.size(), 0);
    check("wb_q_drained", wb_q.size(), 0);
    check("err_q_drained", err_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
